ct_field_restore: RTL and testbench

Return-path companion to the field converter on the GENIE streaming interconnect. On the request path it strips a tag field (the originating field value) from each accepted request and stores it in an in-order tag FIFO. On the response path it pops that tag and re-attaches it to the matching response, so responses leave carrying the field value their request arrived with. Responses must come back in request order; the block also bounds the number of outstanding requests to DEPTH.

---
 rtl/ct_field_restore.sv | 126 ++++++++++++
 tb/tb_ct_field_restore.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_field_restore.sv
// ct_field_restore
// Return-path companion to the field converter. Each accepted request has
// its tag field stripped and pushed into an in-order tag FIFO. Each returning
// response pops the oldest tag and leaves through a one-entry output register
// with that tag re-attached. Requests are throttled so that no more than DEPTH
// are outstanding at any time.
//
// Ports:
//   clk, reset           clock; asynchronous active-low reset (0 = in reset)
//   i_req_*/o_req_ready  upstream request (data, field, valid) and its ready
//   o_req_*/i_req_ready  downstream request with the field removed
//   i_rsp_*/o_rsp_ready  returning response from downstream
//   o_rsp_*/i_rsp_ready  restored response (data, field, valid), registered
//   o_outstanding        current number of tags held in the FIFO
//   o_underflow          sticky flag: a response arrived with no tag waiting
module ct_field_restore #(
  parameter int WDQ   = 8,
  parameter int WDR   = 8,
  parameter int WF    = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WDQ-1:0]             i_req_data,
  input  logic [WF-1:0]              i_req_field,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  output logic [WDQ-1:0]             o_req_data,
  output logic                       o_req_valid,
  input  logic                       i_req_ready,
  input  logic [WDR-1:0]             i_rsp_data,
  input  logic                       i_rsp_valid,
  output logic                       o_rsp_ready,
  output logic [WDR-1:0]             o_rsp_data,
  output logic [WF-1:0]              o_rsp_field,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_outstanding,
  output logic                       o_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WF-1:0] tag_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          out_free;
  logic          push;
  logic          pop;

  // full/empty come only from registered occupancy, which keeps i_req_* out
  // of o_rsp_ready and i_rsp_ready out of o_req_*; it also means a tag pushed
  // this cycle cannot be popped until the next one.
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign out_free = !o_rsp_valid || i_rsp_ready;

  assign o_req_data  = i_req_data;
  assign o_req_valid = i_req_valid && !full;
  assign o_req_ready = i_req_ready && !full;
  assign o_rsp_ready = !empty && out_free;

  assign push = i_req_valid && i_req_ready && !full;
  assign pop  = i_rsp_valid && o_rsp_ready;

  assign o_outstanding = count;

  // Tag storage carries no reset; an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr] <= i_req_field;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Output register: loads on a pop, empties when drained without a reload,
  // and otherwise holds everything stable under backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_field <= '0;
    end else if (pop) begin
      o_rsp_valid <= 1'b1;
      o_rsp_data  <= i_rsp_data;
      o_rsp_field <= tag_mem[rd_ptr];
    end else if (i_rsp_ready) begin
      o_rsp_valid <= 1'b0;
    end
  end

  // A response presented with no tag waiting is a protocol error; it is only
  // recorded, the response itself just stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_underflow <= 1'b0;
    end else if (i_rsp_valid && empty) begin
      o_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ct_field_restore.sv
// tb_ct_field_restore
// Directed bench for ct_field_restore (WDQ=8, WDR=8, WF=4, DEPTH=4). A queue
// model of the tag FIFO and output register predicts every output; a compare
// process checks the DUT against it on each falling edge, and literal
// expectations along the directed sequence pin the model itself.
module tb_ct_field_restore;

  localparam int WDQ   = 8;
  localparam int WDR   = 8;
  localparam int WF    = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic           clk;
  logic           reset;
  logic [WDQ-1:0] req_data_in;
  logic [WF-1:0]  req_field_in;
  logic           req_valid_in;
  logic           req_ready_out;
  logic [WDQ-1:0] req_data_out;
  logic           req_valid_out;
  logic           req_ready_in;
  logic [WDR-1:0] rsp_data_in;
  logic           rsp_valid_in;
  logic           rsp_ready_out;
  logic [WDR-1:0] rsp_data_out;
  logic [WF-1:0]  rsp_field_out;
  logic           rsp_valid_out;
  logic           rsp_ready_in;
  logic [CW-1:0]  outstanding;
  logic           underflow;

  int checks = 0;
  int fails  = 0;

  // Model state
  logic [WF-1:0]  tags_m[$];
  logic           rsp_valid_m;
  logic [WDR-1:0] rsp_data_m;
  logic [WF-1:0]  rsp_field_m;
  logic           underflow_m;

  ct_field_restore #(.WDQ(WDQ), .WDR(WDR), .WF(WF), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_req_data   (req_data_in),
    .i_req_field  (req_field_in),
    .i_req_valid  (req_valid_in),
    .o_req_ready  (req_ready_out),
    .o_req_data   (req_data_out),
    .o_req_valid  (req_valid_out),
    .i_req_ready  (req_ready_in),
    .i_rsp_data   (rsp_data_in),
    .i_rsp_valid  (rsp_valid_in),
    .o_rsp_ready  (rsp_ready_out),
    .o_rsp_data   (rsp_data_out),
    .o_rsp_field  (rsp_field_out),
    .o_rsp_valid  (rsp_valid_out),
    .i_rsp_ready  (rsp_ready_in),
    .o_outstanding(outstanding),
    .o_underflow  (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [WF-1:0] rf,
                               input logic [WDQ-1:0] rd, input logic rr,
                               input logic sv, input logic [WDR-1:0] sd,
                               input logic sr);
    req_valid_in = rv;
    req_field_in = rf;
    req_data_in  = rd;
    req_ready_in = rr;
    rsp_valid_in = sv;
    rsp_data_in  = sd;
    rsp_ready_in = sr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: the FIFO is a queue of tags; a response pops the oldest tag only
  // if one was already waiting at the start of the cycle and the output slot
  // is free; a request is accepted only while fewer than DEPTH are waiting.
  initial begin
    tags_m.delete();
    rsp_valid_m = 1'b0;
    rsp_data_m  = '0;
    rsp_field_m = '0;
    underflow_m = 1'b0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        tags_m.delete();
        rsp_valid_m = 1'b0;
        rsp_data_m  = '0;
        rsp_field_m = '0;
        underflow_m = 1'b0;
      end else begin
        int  n;
        bit  take_rsp;
        bit  take_req;
        n        = tags_m.size();
        take_rsp = rsp_valid_in && (n > 0) && (!rsp_valid_m || rsp_ready_in);
        take_req = req_valid_in && req_ready_in && (n < DEPTH);
        if (rsp_valid_in && n == 0) underflow_m = 1'b1;
        if (take_rsp) begin
          rsp_field_m = tags_m.pop_front();
          rsp_data_m  = rsp_data_in;
          rsp_valid_m = 1'b1;
        end else if (rsp_ready_in) begin
          rsp_valid_m = 1'b0;
        end
        if (take_req) tags_m.push_back(req_field_in);
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      begin
        bit room;
        bit have;
        room = tags_m.size() < DEPTH;
        have = tags_m.size() > 0;
        checkOutput("cmp_req_valid", 32'(req_valid_out), 32'(req_valid_in && room));
        checkOutput("cmp_req_ready", 32'(req_ready_out), 32'(req_ready_in && room));
        checkOutput("cmp_req_data", 32'(req_data_out), 32'(req_data_in));
        checkOutput("cmp_rsp_ready", 32'(rsp_ready_out),
                    32'(have && (!rsp_valid_m || rsp_ready_in)));
        checkOutput("cmp_rsp_valid", 32'(rsp_valid_out), 32'(rsp_valid_m));
        checkOutput("cmp_rsp_data", 32'(rsp_data_out), 32'(rsp_data_m));
        checkOutput("cmp_rsp_field", 32'(rsp_field_out), 32'(rsp_field_m));
        checkOutput("cmp_outstanding", 32'(outstanding), 32'(tags_m.size()));
        checkOutput("cmp_underflow", 32'(underflow), 32'(underflow_m));
      end
    end
  end

  initial begin
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    #1;
    checkOutput("reset_rsp_valid", 32'(rsp_valid_out), 0);
    checkOutput("reset_outstanding", 32'(outstanding), 0);
    checkOutput("reset_underflow", 32'(underflow), 0);
    checkOutput("reset_rsp_data", 32'(rsp_data_out), 0);
    checkOutput("reset_rsp_field", 32'(rsp_field_out), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    $display("[TB] single round trip");
    applyStimulus(1, 4'h5, 8'h11, 1, 0, 0, 1);
    #1;
    checkOutput("rt_req_valid", 32'(req_valid_out), 1);
    checkOutput("rt_req_ready", 32'(req_ready_out), 1);
    step();
    checkOutput("rt_outstanding_1", 32'(outstanding), 1);
    applyStimulus(0, 0, 0, 1, 1, 8'hAB, 1);
    #1;
    checkOutput("rt_rsp_ready", 32'(rsp_ready_out), 1);
    step();
    checkOutput("rt_rsp_valid", 32'(rsp_valid_out), 1);
    checkOutput("rt_rsp_data", 32'(rsp_data_out), 32'hAB);
    checkOutput("rt_rsp_field", 32'(rsp_field_out), 32'h5);
    checkOutput("rt_outstanding_0", 32'(outstanding), 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    step();
    checkOutput("rt_drained", 32'(rsp_valid_out), 0);

    $display("[TB] ordering and wrap");
    for (int i = 0; i <= 10; i++) begin
      applyStimulus(i < 10, WF'(i), WDQ'(i), 1, i > 0, WDR'(8'h80 + i), 1);
      step();
      if (i > 0) begin
        checkOutput("wrap_field", 32'(rsp_field_out), 32'(i - 1));
        checkOutput("wrap_data", 32'(rsp_data_out), 32'(8'h80 + i));
      end
    end
    checkOutput("wrap_outstanding", 32'(outstanding), 0);

    $display("[TB] full");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, WF'(4'hA + i), 8'h00, 1, 0, 0, 1);
      step();
    end
    checkOutput("full_outstanding", 32'(outstanding), 4);
    applyStimulus(1, 4'hE, 8'h00, 1, 1, 8'hC0, 1);
    #1;
    checkOutput("full_req_ready", 32'(req_ready_out), 0);
    checkOutput("full_req_valid", 32'(req_valid_out), 0);
    step();
    checkOutput("full_push_blocked", 32'(outstanding), 3);
    checkOutput("full_pop_field", 32'(rsp_field_out), 32'hA);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 1, WDR'(8'hC1 + i), 1);
      step();
      checkOutput("full_drain_field", 32'(rsp_field_out), 32'(4'hB + i));
    end
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    step();

    $display("[TB] empty stall and underflow");
    applyStimulus(1, 4'h7, 8'h22, 1, 1, 8'h3C, 1);
    #1;
    checkOutput("uf_rsp_ready", 32'(rsp_ready_out), 0);
    step();
    checkOutput("uf_set", 32'(underflow), 1);
    checkOutput("uf_no_pop", 32'(rsp_valid_out), 0);
    checkOutput("uf_tag_held", 32'(outstanding), 1);
    applyStimulus(0, 0, 0, 1, 1, 8'h3C, 1);
    #1;
    checkOutput("uf_rsp_ready_next", 32'(rsp_ready_out), 1);
    step();
    checkOutput("uf_pop_field", 32'(rsp_field_out), 32'h7);
    checkOutput("uf_sticky", 32'(underflow), 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    step();

    $display("[TB] backpressure");
    applyStimulus(1, 4'h1, 8'h00, 1, 0, 0, 1);
    step();
    applyStimulus(1, 4'h2, 8'h00, 1, 0, 0, 1);
    step();
    applyStimulus(0, 0, 0, 1, 1, 8'hD1, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 1, 1, 8'hD2, 0);
      #1;
      checkOutput("bp_rsp_ready", 32'(rsp_ready_out), 0);
      step();
      checkOutput("bp_hold_valid", 32'(rsp_valid_out), 1);
      checkOutput("bp_hold_data", 32'(rsp_data_out), 32'hD1);
      checkOutput("bp_hold_field", 32'(rsp_field_out), 32'h1);
    end
    applyStimulus(0, 0, 0, 1, 1, 8'hD2, 1);
    #1;
    checkOutput("bp_release_ready", 32'(rsp_ready_out), 1);
    step();
    checkOutput("bp_next_valid", 32'(rsp_valid_out), 1);
    checkOutput("bp_next_data", 32'(rsp_data_out), 32'hD2);
    checkOutput("bp_next_field", 32'(rsp_field_out), 32'h2);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    step();

    $display("[TB] async reset mid-stream");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, WF'(3 + i), 8'h00, 1, 0, 0, 1);
      step();
    end
    applyStimulus(0, 0, 0, 1, 1, 8'hE3, 1);
    step();
    checkOutput("ar_pre_outstanding", 32'(outstanding), 3);
    checkOutput("ar_pre_valid", 32'(rsp_valid_out), 1);
    applyStimulus(1, 4'h0, 8'h33, 1, 0, 0, 0);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("ar_outstanding", 32'(outstanding), 0);
    checkOutput("ar_rsp_valid", 32'(rsp_valid_out), 0);
    checkOutput("ar_rsp_field", 32'(rsp_field_out), 0);
    checkOutput("ar_req_passthru", 32'(req_valid_out), 1);
    step();
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    reset = 1'b1;
    applyStimulus(1, 4'h9, 8'h44, 1, 0, 0, 1);
    step();
    checkOutput("ar_new_outstanding", 32'(outstanding), 1);
    applyStimulus(0, 0, 0, 1, 1, 8'h5A, 1);
    step();
    checkOutput("ar_new_data", 32'(rsp_data_out), 32'h5A);
    checkOutput("ar_new_field", 32'(rsp_field_out), 32'h9);
    checkOutput("ar_new_underflow", 32'(underflow), 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
